// File: rtl/ula_fx_arb.sv
// rtl/ula_fx_arb.sv - round-robin arbiter/sequencer sharing one ula_fx ALU
// Grants one requester at a time, holds the ALU inputs for the opcode latency, returns a registered result.
module ula_fx_arb #(
   parameter int NUBITS = 32,
   parameter int NREQ   = 4,
   parameter int DIVLAT = 4,
   parameter int MLTLAT = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   output logic [NREQ-1:0]        req_ready,
   input  logic [5*NREQ-1:0]      req_op,
   input  logic [NUBITS*NREQ-1:0] req_in1,
   input  logic [NUBITS*NREQ-1:0] req_in2,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [NUBITS-1:0]      rsp_data,
   output logic                   rsp_zero,
   output logic                   rsp_err,
   output logic [4:0]             alu_op,
   output logic [NUBITS-1:0]      alu_in1,
   output logic [NUBITS-1:0]      alu_in2,
   input  logic [NUBITS-1:0]      alu_out,
   input  logic                   alu_is_zero,
   output logic                   busy
);
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int LMAX = (DIVLAT > MLTLAT) ? DIVLAT : MLTLAT;
   localparam int CW   = (LMAX > 1) ? $clog2(LMAX) : 1;

   typedef enum logic {S_IDLE, S_EXEC} state_t;

   state_t            r_state;
   logic [PW-1:0]     r_ptr;
   logic [PW-1:0]     r_gnt;
   logic [CW-1:0]     r_cnt;
   logic              r_illegal;
   logic              r_busy;
   logic [4:0]        r_alu_op;
   logic [NUBITS-1:0] r_alu_in1;
   logic [NUBITS-1:0] r_alu_in2;
   logic [NREQ-1:0]   r_rsp_valid;
   logic [NUBITS-1:0] r_rsp_data;
   logic              r_rsp_zero;
   logic              r_rsp_err;

   logic              w_any;
   logic [PW-1:0]     w_win;
   logic [PW:0]       w_idx;
   logic [4:0]        w_op;
   logic [NUBITS-1:0] w_in1;
   logic [NUBITS-1:0] w_in2;
   logic              w_illegal;
   logic [CW-1:0]     w_lat;

   // Scan downward so the last hit wins: that is the first valid bit at or after r_ptr.
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = {1'b0, r_ptr} + (PW+1)'(k);
         if (w_idx >= (PW+1)'(NREQ)) begin
            w_idx = w_idx - (PW+1)'(NREQ);
         end
         if (req_valid[w_idx[PW-1:0]]) begin
            w_any = 1'b1;
            w_win = w_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      w_op      = req_op[5*int'(w_win) +: 5];
      w_in1     = req_in1[NUBITS*int'(w_win) +: NUBITS];
      w_in2     = req_in2[NUBITS*int'(w_win) +: NUBITS];
      w_illegal = (w_op > 5'd25);
      case (w_op)
         5'd3:       w_lat = CW'(MLTLAT - 1);
         5'd4, 5'd5: w_lat = CW'(DIVLAT - 1);
         default:    w_lat = '0;
      endcase
   end

   assign req_ready = (!rst && r_state == S_IDLE && w_any)
                      ? ({{(NREQ-1){1'b0}}, 1'b1} << w_win) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_cnt       <= '0;
         r_illegal   <= 1'b0;
         r_busy      <= 1'b0;
         r_alu_op    <= '0;
         r_alu_in1   <= '0;
         r_alu_in2   <= '0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_rsp_zero  <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_rsp_valid <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt     <= w_win;
                  r_cnt     <= w_lat;
                  r_illegal <= w_illegal;
                  r_alu_op  <= w_illegal ? 5'd0 : w_op;
                  r_alu_in1 <= w_in1;
                  r_alu_in2 <= w_in2;
                  r_busy    <= 1'b1;
                  r_state   <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CW'(1);
               end else begin
                  r_rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << r_gnt;
                  r_rsp_data  <= r_illegal ? '0 : alu_out;
                  r_rsp_zero  <= r_illegal ? 1'b1 : alu_is_zero;
                  r_rsp_err   <= r_illegal;
                  r_ptr       <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + PW'(1);
                  r_alu_op    <= '0;
                  r_alu_in1   <= '0;
                  r_alu_in2   <= '0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_zero  = r_rsp_zero;
   assign rsp_err   = r_rsp_err;
   assign alu_op    = r_alu_op;
   assign alu_in1   = r_alu_in1;
   assign alu_in2   = r_alu_in2;
   assign busy      = r_busy;

endmodule

// File: tb/tb_ula_fx_arb.sv
// tb/tb_ula_fx_arb.sv - self-checking bench for ula_fx_arb with a behavioural ula_fx stand-in
// Expected responses are queued at each grant and matched when rsp_valid fires.
module tb_ula_fx_arb;
   localparam int NUBITS = 32;
   localparam int NREQ   = 4;
   localparam int DIVLAT = 4;
   localparam int MLTLAT = 2;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic [NREQ-1:0]        req_valid = '0;
   logic [NREQ-1:0]        req_ready;
   logic [5*NREQ-1:0]      req_op = '0;
   logic [NUBITS*NREQ-1:0] req_in1 = '0;
   logic [NUBITS*NREQ-1:0] req_in2 = '0;
   logic [NREQ-1:0]        rsp_valid;
   logic [NUBITS-1:0]      rsp_data;
   logic                   rsp_zero;
   logic                   rsp_err;
   logic [4:0]             alu_op;
   logic [NUBITS-1:0]      alu_in1;
   logic [NUBITS-1:0]      alu_in2;
   logic [NUBITS-1:0]      alu_out;
   logic                   alu_is_zero;
   logic                   busy;

   typedef struct {
      int          req;
      logic [31:0] data;
      logic        zero;
      logic        err;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   ula_fx_arb #(.NUBITS(NUBITS), .NREQ(NREQ), .DIVLAT(DIVLAT), .MLTLAT(MLTLAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_in1(req_in1), .req_in2(req_in2),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_out(alu_out), .alu_is_zero(alu_is_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         5'd0:    return b;
         5'd1:    return a;
         5'd2:    return a + b;
         5'd3:    return a * b;
         5'd4:    return (b == 0) ? 32'd0 : 32'($signed(a) / $signed(b));
         5'd5:    return (b == 0) ? 32'd0 : 32'($signed(a) % $signed(b));
         5'd17:   return (a == b) ? 32'd1 : 32'd0;
         default: return a - b;
      endcase
   endfunction

   function automatic int lat_of(input logic [4:0] op);
      if (op == 5'd3) return MLTLAT;
      if (op == 5'd4 || op == 5'd5) return DIVLAT;
      return 1;
   endfunction

   assign alu_out     = alu_fn(alu_op, alu_in1, alu_in2);
   assign alu_is_zero = (alu_out == 32'd0);

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Response monitor: every rsp_valid must match the oldest queued expectation, on time.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         n_vec++;
         if ((req_ready & {NREQ{busy}}) !== '0) begin
            n_err++;
            $display("FAIL ready_while_busy req_ready=%b busy=%b expected no ready while busy", req_ready, busy);
         end
         if (sb.size() > 0 && cyc > sb[0].due) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_rsp cyc=%0d expected rsp for req %0d at cyc %0d", cyc, sb[0].req, sb[0].due);
            void'(sb.pop_front());
         end
         if (rsp_valid !== '0) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_rsp rsp_valid=%b cyc=%0d expected no response", rsp_valid, cyc);
            end else begin
               e = sb.pop_front();
               if (rsp_valid !== (4'b1 << e.req) || rsp_data !== e.data || rsp_zero !== e.zero ||
                   rsp_err !== e.err || cyc != e.due) begin
                  n_err++;
                  $display("FAIL rsp_check got valid=%b data=%h zero=%b err=%b cyc=%0d expected valid=%b data=%h zero=%b err=%b cyc=%0d",
                           rsp_valid, rsp_data, rsp_zero, rsp_err, cyc,
                           4'(4'b1 << e.req), e.data, e.zero, e.err, e.due);
               end
            end
         end
      end
   end

   task automatic issue(input int i, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[5*i +: 5]   = op;
      req_in1[32*i +: 32] = a;
      req_in2[32*i +: 32] = b;
      req_valid[i]        = 1'b1;
   endtask

   // Waits for requester i's grant, queues its expected response, then drops valid.
   task automatic wait_grant(input int i, input int maxc, output bit ok);
      exp_t        e;
      logic [4:0]  op;
      ok = 1'b0;
      for (int c = 0; c < maxc && !ok; c++) begin
         #1;
         if (req_ready[i]) begin
            op     = req_op[5*i +: 5];
            e.req  = i;
            e.data = (op > 5'd25) ? 32'd0 : alu_fn(op, req_in1[32*i +: 32], req_in2[32*i +: 32]);
            e.zero = (e.data == 32'd0);
            e.err  = (op > 5'd25);
            e.due  = cyc + 1 + lat_of(op);
            sb.push_back(e);
            ok = 1'b1;
            @(negedge clk);
            req_valid[i] = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic drain(input int maxc, output bit ok);
      for (int c = 0; c < maxc && sb.size() != 0; c++) begin
         @(negedge clk);
         #1;
      end
      ok = (sb.size() == 0);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if ({req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_op, alu_in1, alu_in2, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs ready=%b rsp_valid=%b data=%h zero=%b err=%b alu_op=%0d busy=%b expected all 0",
                  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_op, busy);
      end
      rst = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({rsp_valid, busy, alu_op} !== '0) begin
         n_err++;
         $display("FAIL reset_release rsp_valid=%b busy=%b alu_op=%0d expected 0", rsp_valid, busy, alu_op);
      end
   endtask

   task automatic test_single_add();
      bit ok;
      issue(0, 5'd2, 32'd5, 32'd7);
      #1;
      n_vec++;
      if (req_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL add_ready got %b expected 0001", req_ready);
      end
      wait_grant(0, 2, ok);
      drain(10, ok);
      n_vec++;
      if (!ok || rsp_data !== 32'd12 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
         n_err++;
         $display("FAIL add_result done=%b data=%0d zero=%b err=%b expected done=1 data=12 zero=0 err=0",
                  ok, rsp_data, rsp_zero, rsp_err);
      end
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      int g = 0, last = 0, drop = -1;
      bit raise0 = 0, seen0 = 0, ok;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      for (int i = 0; i < NREQ; i++) issue(i, 5'd0, 32'd0, 32'(i));
      for (int c = 0; c < 30 && g < 5; c++) begin
         if (raise0) begin req_valid[0] = 1'b1; raise0 = 0; end
         if (drop >= 0) begin req_valid[drop] = 1'b0; drop = -1; end
         #1;
         if (req_ready !== '0) begin
            exp_t e;
            n_vec++;
            if (req_ready !== (4'b1 << order[g])) begin
               n_err++;
               $display("FAIL rr_order grant %0d got ready=%b expected %b", g, req_ready, 4'(4'b1 << order[g]));
            end
            if (g > 0) begin
               n_vec++;
               if (cyc - last != 2) begin
                  n_err++;
                  $display("FAIL rr_spacing grant %0d got %0d cycles expected 2", g, cyc - last);
               end
            end
            for (int j = 0; j < NREQ; j++) if (req_ready[j]) drop = j;
            e.req = drop; e.data = 32'(drop); e.zero = (drop == 0); e.err = 1'b0; e.due = cyc + 2;
            sb.push_back(e);
            last = cyc;
            g++;
         end
         if (rsp_valid[0] && !seen0) begin seen0 = 1; raise0 = 1; end
         @(negedge clk);
      end
      req_valid = '0;
      n_vec++;
      if (g != 5) begin
         n_err++;
         $display("FAIL rr_count got %0d grants expected 5", g);
      end
      drain(10, ok);
   endtask

   task automatic test_div();
      bit ok;
      issue(2, 5'd4, 32'hFFFF_FF9C, 32'd7);
      wait_grant(2, 4, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL div_grant got none expected grant to 2"); end
      issue(1, 5'd2, 32'd1, 32'd1);
      for (int k = 0; k < DIVLAT; k++) begin
         #1;
         n_vec++;
         if (alu_op !== 5'd4 || alu_in1 !== 32'hFFFF_FF9C || alu_in2 !== 32'd7 || req_ready !== '0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL div_hold k=%0d op=%0d in1=%h in2=%h ready=%b busy=%b expected op=4 in1=ffffff9c in2=7 ready=0 busy=1",
                     k, alu_op, alu_in1, alu_in2, req_ready, busy);
         end
         @(negedge clk);
      end
      wait_grant(1, 1, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL div_next_grant got none expected grant to 1 in rsp cycle"); end
      drain(10, ok);
   endtask

   task automatic test_zero_illegal();
      bit ok;
      issue(3, 5'd17, 32'd3, 32'd3);
      wait_grant(3, 6, ok);
      drain(10, ok);
      n_vec++;
      if (rsp_data !== 32'd1 || rsp_zero !== 1'b0) begin
         n_err++;
         $display("FAIL equ got data=%0d zero=%b expected data=1 zero=0", rsp_data, rsp_zero);
      end
      issue(3, 5'd2, 32'd3, 32'hFFFF_FFFD);
      wait_grant(3, 6, ok);
      drain(10, ok);
      n_vec++;
      if (rsp_zero !== 1'b1 || rsp_data !== 32'd0) begin
         n_err++;
         $display("FAIL add_zero got data=%h zero=%b expected data=0 zero=1", rsp_data, rsp_zero);
      end
      issue(3, 5'd30, 32'd5, 32'd9);
      wait_grant(3, 6, ok);
      #1;
      n_vec++;
      if (busy !== 1'b1 || alu_op !== 5'd0) begin
         n_err++;
         $display("FAIL illegal_aluop got busy=%b alu_op=%0d expected busy=1 alu_op=0", busy, alu_op);
      end
      drain(10, ok);
      n_vec++;
      if (rsp_data !== 32'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b1) begin
         n_err++;
         $display("FAIL illegal got data=%h zero=%b err=%b expected 0 1 1", rsp_data, rsp_zero, rsp_err);
      end
      issue(3, 5'd2, 32'd1, 32'd2);
      wait_grant(3, 6, ok);
      drain(10, ok);
      n_vec++;
      if (rsp_err !== 1'b0 || rsp_data !== 32'd3) begin
         n_err++;
         $display("FAIL err_clear got err=%b data=%0d expected err=0 data=3", rsp_err, rsp_data);
      end
   endtask

   task automatic test_reset_mid_op();
      bit ok;
      issue(1, 5'd2, 32'd4, 32'd4);
      wait_grant(1, 6, ok);
      drain(10, ok);
      issue(2, 5'd4, 32'd100, 32'd3);
      wait_grant(2, 6, ok);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_vec++;
      if ({req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_op, alu_in1, alu_in2, busy} !== '0) begin
         n_err++;
         $display("FAIL midop_reset ready=%b rsp_valid=%b data=%h zero=%b err=%b alu_op=%0d busy=%b expected all 0",
                  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_op, busy);
      end
      repeat (6) @(negedge clk);
      issue(3, 5'd0, 32'd0, 32'd33);
      issue(0, 5'd0, 32'd0, 32'd44);
      #1;
      n_vec++;
      if (req_ready !== 4'b0001) begin
         n_err++;
         $display("FAIL midop_ptr got ready=%b expected 0001", req_ready);
      end
      wait_grant(0, 1, ok);
      wait_grant(3, 6, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL midop_second got no grant expected grant to 3"); end
      drain(10, ok);
   endtask

   task automatic test_withdrawn();
      bit ok, got = 0, hit3 = 0;
      issue(2, 5'd4, 32'd50, 32'd5);
      wait_grant(2, 6, ok);
      issue(1, 5'd2, 32'd2, 32'd3);
      issue(3, 5'd2, 32'd7, 32'd7);
      @(negedge clk);
      req_valid[3] = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         #1;
         if (req_ready[3]) hit3 = 1;
         if (req_ready[1]) got = 1;
         else @(negedge clk);
      end
      n_vec++;
      if (hit3 || !got) begin
         n_err++;
         $display("FAIL withdrawn got hit3=%b grant1=%b expected hit3=0 grant1=1", hit3, got);
      end
      wait_grant(1, 1, ok);
      drain(10, ok);
      n_vec++;
      if (!ok || rsp_data !== 32'd5) begin
         n_err++;
         $display("FAIL withdrawn_rsp done=%b data=%0d expected done=1 data=5", ok, rsp_data);
      end
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_round_robin();
      test_div();
      test_zero_illegal();
      test_reset_mid_op();
      test_withdrawn();
      repeat (4) @(negedge clk);
      n_vec++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_left got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ula_fx_arb.md
# ula_fx_arb

Round-robin arbiter and sequencer that shares a single `ula_fx` fixed-point ALU instance between `NREQ` requesters (processor cores, DMA/normalisation engines). Each requester issues one ALU operation at a time through a valid/ready handshake. The block then:
- registers the winning operands,
- holds the ALU inputs stable for a fixed number of cycles per opcode (multi-cycle path for DIV/MOD),
- returns the registered result and zero flag on a one-cycle response strobe.

It sits between the requesters and the `ula_fx` combinational datapath.

## Interface
Parameters:
- `NUBITS`, 32, data width; must match the attached `ula_fx`.
- `NREQ`, 4, number of requesters, 2..8.
- `DIVLAT`, 4, EXEC cycles for op 4 (DIV) and op 5 (MOD), ≥1.
- `MLTLAT`, 2, EXEC cycles for op 3 (MLT), ≥1.

Ports (a requester *i* owns slice *i* of each packed bus):
- `clk`  in  1  clock; every register updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  NREQ  request pending per requester.
- `req_ready`  out  NREQ  one-hot accept pulse.
- `req_op`  in  5*NREQ  ALU opcode per requester.
- `req_in1`  in  NUBITS*NREQ  operand 1 per requester.
- `req_in2`  in  NUBITS*NREQ  operand 2 per requester.
- `rsp_valid`  out  NREQ  one-hot result strobe.
- `rsp_data`  out  NUBITS  result, shared by all requesters.
- `rsp_zero`  out  1  registered `is_zero` of the result.
- `rsp_err`  out  1  opcode was illegal (>25).
- `alu_op`  out  5  to `ula_fx.op`.
- `alu_in1`  out  NUBITS  to `ula_fx.in1`.
- `alu_in2`  out  NUBITS  to `ula_fx.in2`.
- `alu_out`  in  NUBITS  from `ula_fx.out`.
- `alu_is_zero`  in  1  from `ula_fx.is_zero`.
- `busy`  out  1  high in EXEC.

## Operation
- States: IDLE, EXEC.
- **IDLE:**
  - If any `req_valid` bit is high, select the winner: the first set bit found scanning upward (with wrap) from pointer `ptr`.
  - Assert `req_ready[winner]` combinationally in that cycle.
  - On the edge: latch op/in1/in2 into `op_r`/`a_r`/`b_r`, store `gnt_r=winner`, load `cnt` with the latency minus 1, go to EXEC.
- **Latency per opcode:**
  - op 3: `MLTLAT`.
  - op 4, op 5: `DIVLAT`.
  - ops 0–2 and 6–25: 1.
  - op > 25: 1, and the request is flagged illegal.
- **EXEC:**
  - `alu_op`/`alu_in1`/`alu_in2` are driven from `op_r`/`a_r`/`b_r` and stay constant throughout EXEC.
  - `cnt` decrements each cycle while nonzero.
  - At `cnt==0` on the edge:
    - `rsp_data <= alu_out` and `rsp_zero <= alu_is_zero`.
    - `rsp_valid[gnt_r] <= 1` for exactly one cycle.
    - `ptr <= gnt_r+1` (mod NREQ).
    - Go to IDLE.
- **Illegal op:**
  - `rsp_data <= 0`, `rsp_zero <= 1`, `rsp_err <= 1`.
  - `alu_op` is driven to 0 (NOP) during EXEC.
- **Idle outputs:**
  - `alu_op=0`, `alu_in1=0`, `alu_in2=0`; the ALU output is ignored.
  - `rsp_data`, `rsp_zero` and `rsp_err` hold the last response until the next response.
- **Requester obligations:**
  - Hold valid/op/operands stable until ready.
  - Deassert or change valid only after ready.
  - A requester may re-raise valid in the cycle after its `rsp_valid`.
- `rsp_valid` has no backpressure; the requester must capture it in that cycle.
- `req_valid` falling before it is granted is legal; the request is not granted and nothing is recorded.
- Fairness: a requester that holds `req_valid` is granted within NREQ grants.
- **Reset:**
  - All outputs 0, `ptr=0`, state IDLE.
  - An in-flight operation is discarded and no `rsp_valid` is issued.

## Timing
- Accept edge T (valid&ready high) → `rsp_valid` high in cycle T+L+1, where L is the op latency. Example: ADD accepted at T gives response at T+2; DIV with DIVLAT=4 gives T+5.
- `req_ready` is never asserted in EXEC. The next grant can occur in the cycle `rsp_valid` is high (IDLE), so peak throughput is one op per L+1 cycles.
- `req_ready` and `rsp_valid` are each one-hot or zero; `req_ready` is never asserted together with `busy`.
- The ALU inputs are constant for all L EXEC cycles. The `ula_fx` DIV/MOD path is constrained as a DIVLAT-cycle multicycle path from `a_r`/`b_r`/`op_r` to `rsp_data`.
- `rsp_err` and `rsp_zero` update only on a response edge.

## Test plan
- **Single ADD:** reset, then requester 0 sends op 2, in1=5, in2=7. Expect `req_ready[0]` in the request cycle, `rsp_valid[0]` two cycles later, `rsp_data=12`, `rsp_zero=0`, `rsp_err=0`.
- **Round-robin:** all four requesters hold valid with op 0 (NOP, in2=i). Expect grant order 0,1,2,3,0 with `ptr` wrapping, each `rsp_data=i`, and one grant every 2 cycles.
- **Multi-cycle DIV:** DIVLAT=4, requester 2 sends op 4, in1=-100, in2=7. Expect `alu_in1`/`alu_in2` stable for 4 cycles, `rsp_valid[2]` at T+5 with `rsp_data=-14`, and requester 1 held off (ready low) the whole time.
- **Zero and illegal:** op 17 (EQU) with in1=in2=3 → `rsp_data=1`, `rsp_zero=0`. Op 2 with 3 and -3 → `rsp_zero=1`. Op 30 → `rsp_data=0`, `rsp_zero=1`, `rsp_err=1`, and `alu_op=0` during EXEC.
- **Reset mid-op:** assert `rst` during the second EXEC cycle of a DIV. Expect no `rsp_valid`, all outputs 0 and `ptr=0` the cycle after, and a new request accepted normally.
- **Withdrawn request:** requester 3 pulses valid for one cycle while EXEC is busy. Expect no grant to requester 3, and a later grant goes to the other pending requester.
